// File: rtl/player_death_ctrl.sv
// ---------------------------------------------------------------------------
// player_death_ctrl
//   Turns raw player hit events into a timed death sequence: freeze, death
//   animation, a one-cycle player_died pulse to the life counter, then either
//   a respawn (with a grace window of hit immunity) or a sticky game over.
//
// Ports
//   clk            in  system clock
//   resetN         in  asynchronous active-low reset
//   startOfFrame   in  one-cycle pulse per video frame (frame-count tick)
//   hit_monster    in  player/monster collision level
//   hit_gold       in  player/falling-gold collision level
//   no_lives       in  1 = life counter is exhausted (read at end of WAIT)
//   player_died    out one-cycle pulse, decrements the life counter
//   respawn        out one-cycle pulse, player reloads its start position
//   player_freeze  out 1 = movement and digging disabled
//   player_visible out 1 = sprite drawn
//   dying_anim     out 1 = sprite shows the death bitmap
//   game_over      out sticky game-over flag
//
// Build option
//   PLAYER_DEATH_BLINK_EN : sprite blinks with period BLINK_PERIOD frames
//                           while grace immunity is active. Without it the
//                           sprite stays visible throughout ALIVE.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ALIVE     | normal play; hits accepted once grace_cnt has run out
// DYING     | frozen, death bitmap shown, counting DEATH_FRAMES ticks
// DIED      | single clk, player_died pulses
// WAIT      | frozen and hidden, counting RESPAWN_FRAMES, then reads no_lives
// GAME_OVER | absorbing; only resetN leaves it
// ---------------------------------------------------------------------------
module player_death_ctrl #(
  parameter int unsigned DEATH_FRAMES   = 60,
  parameter int unsigned RESPAWN_FRAMES = 30,
  parameter int unsigned GRACE_FRAMES   = 90
`ifdef PLAYER_DEATH_BLINK_EN
  ,
  parameter int unsigned BLINK_PERIOD   = 8
`endif
) (
  input  logic clk,
  input  logic resetN,
  input  logic startOfFrame,
  input  logic hit_monster,
  input  logic hit_gold,
  input  logic no_lives,
  output logic player_died,
  output logic respawn,
  output logic player_freeze,
  output logic player_visible,
  output logic dying_anim,
  output logic game_over
);

  typedef enum logic [2:0] {
    ST_ALIVE,
    ST_DYING,
    ST_DIED,
    ST_WAIT,
    ST_GAME_OVER
  } state_t;

  localparam logic [7:0] DEATH_CNT   = 8'(DEATH_FRAMES);
  localparam logic [7:0] RESPAWN_CNT = 8'(RESPAWN_FRAMES);
  localparam logic [7:0] GRACE_CNT   = 8'(GRACE_FRAMES);

  state_t     state_q, state_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [7:0] grace_cnt_q, grace_cnt_d;
  logic       player_died_q, player_died_d;
  logic       respawn_q, respawn_d;
  logic       player_freeze_q, player_freeze_d;
  logic       player_visible_q, player_visible_d;
  logic       dying_anim_q, dying_anim_d;
  logic       game_over_q, game_over_d;
  logic       hit;

`ifdef PLAYER_DEATH_BLINK_EN
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_PERIOD - 1);
  logic [7:0] blink_cnt_q, blink_cnt_d;
  logic       blink_vis_q, blink_vis_d;
`endif

  // Simultaneous collisions collapse into a single event here.
  assign hit = (hit_monster | hit_gold) & (grace_cnt_q == 8'd0);

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    grace_cnt_d = grace_cnt_q;
    respawn_d   = 1'b0;
`ifdef PLAYER_DEATH_BLINK_EN
    blink_cnt_d = blink_cnt_q;
    blink_vis_d = blink_vis_q;
`endif

    case (state_q)
      ST_ALIVE: begin
        // A hit takes priority over a frame tick in the same clk.
        if (hit) begin
          state_d     = ST_DYING;
          frame_cnt_d = 8'd0;
        end else if (startOfFrame && (grace_cnt_q != 8'd0)) begin
          grace_cnt_d = grace_cnt_q - 8'd1;
`ifdef PLAYER_DEATH_BLINK_EN
          if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = 8'd0;
            blink_vis_d = ~blink_vis_q;
          end else begin
            blink_cnt_d = blink_cnt_q + 8'd1;
          end
`endif
        end
      end

      ST_DYING: begin
        if (frame_cnt_q == DEATH_CNT) begin
          state_d = ST_DIED;
        end else if (startOfFrame) begin
          frame_cnt_d = frame_cnt_q + 8'd1;
        end
      end

      ST_DIED: begin
        state_d     = ST_WAIT;
        frame_cnt_d = 8'd0;
      end

      ST_WAIT: begin
        if (frame_cnt_q == RESPAWN_CNT) begin
          if (no_lives) begin
            state_d = ST_GAME_OVER;
          end else begin
            state_d     = ST_ALIVE;
            respawn_d   = 1'b1;
            grace_cnt_d = GRACE_CNT;
`ifdef PLAYER_DEATH_BLINK_EN
            blink_cnt_d = 8'd0;
            blink_vis_d = 1'b1;
`endif
          end
        end else if (startOfFrame) begin
          frame_cnt_d = frame_cnt_q + 8'd1;
        end
      end

      ST_GAME_OVER: begin
        state_d = ST_GAME_OVER;
      end

      default: begin
        state_d     = ST_ALIVE;
        frame_cnt_d = 8'd0;
        grace_cnt_d = 8'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so each one changes on the edge
  // that enters its state.
  always_comb begin
    player_died_d   = (state_d == ST_DIED);
    player_freeze_d = (state_d != ST_ALIVE);
    dying_anim_d    = (state_d == ST_DYING) || (state_d == ST_DIED);
    game_over_d     = (state_d == ST_GAME_OVER);
    if (state_d == ST_ALIVE) begin
`ifdef PLAYER_DEATH_BLINK_EN
      player_visible_d = (grace_cnt_d == 8'd0) | blink_vis_d;
`else
      player_visible_d = 1'b1;
`endif
    end else begin
      player_visible_d = (state_d == ST_DYING) || (state_d == ST_DIED);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q          <= ST_ALIVE;
      frame_cnt_q      <= 8'd0;
      grace_cnt_q      <= 8'd0;
      player_died_q    <= 1'b0;
      respawn_q        <= 1'b0;
      player_freeze_q  <= 1'b0;
      player_visible_q <= 1'b1;
      dying_anim_q     <= 1'b0;
      game_over_q      <= 1'b0;
`ifdef PLAYER_DEATH_BLINK_EN
      blink_cnt_q      <= 8'd0;
      blink_vis_q      <= 1'b1;
`endif
    end else begin
      state_q          <= state_d;
      frame_cnt_q      <= frame_cnt_d;
      grace_cnt_q      <= grace_cnt_d;
      player_died_q    <= player_died_d;
      respawn_q        <= respawn_d;
      player_freeze_q  <= player_freeze_d;
      player_visible_q <= player_visible_d;
      dying_anim_q     <= dying_anim_d;
      game_over_q      <= game_over_d;
`ifdef PLAYER_DEATH_BLINK_EN
      blink_cnt_q      <= blink_cnt_d;
      blink_vis_q      <= blink_vis_d;
`endif
    end
  end

  assign player_died    = player_died_q;
  assign respawn        = respawn_q;
  assign player_freeze  = player_freeze_q;
  assign player_visible = player_visible_q;
  assign dying_anim     = dying_anim_q;
  assign game_over      = game_over_q;

endmodule

// File: tb/tb_player_death_ctrl.sv
// ---------------------------------------------------------------------------
// tb_player_death_ctrl
//   Directed scenarios followed by randomized hits, frame ticks, no_lives and
//   occasional asynchronous resets. A behavioural model tracks the death
//   sequence as "ticks remaining" per phase and predicts every output each clk.
// ---------------------------------------------------------------------------
module tb_player_death_ctrl;

  localparam int DEATH   = 60;
  localparam int RESPAWN = 30;
  localparam int GRACE   = 90;
`ifdef PLAYER_DEATH_BLINK_EN
  localparam int BLINK   = 8;
`endif

  localparam int M_ALIVE = 0;
  localparam int M_DYING = 1;
  localparam int M_DIED  = 2;
  localparam int M_WAIT  = 3;
  localparam int M_OVER  = 4;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic startOfFrame = 1'b0;
  logic hit_monster = 1'b0;
  logic hit_gold = 1'b0;
  logic no_lives = 1'b0;
  logic player_died, respawn, player_freeze, player_visible, dying_anim, game_over;

  int n_checks = 0;
  int n_errors = 0;

  // reference model
  int m_mode;
  int m_left;
  int m_grace;
  int m_died;
  int m_resp;

  int died_obs = 0;
  int resp_obs = 0;
  int over_cycles = 0;
  int base_died, base_resp;
  bit r_hm, r_hg, r_nl, r_sof;

  always #5 clk = ~clk;

  player_death_ctrl dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (startOfFrame),
    .hit_monster    (hit_monster),
    .hit_gold       (hit_gold),
    .no_lives       (no_lives),
    .player_died    (player_died),
    .respawn        (respawn),
    .player_freeze  (player_freeze),
    .player_visible (player_visible),
    .dying_anim     (dying_anim),
    .game_over      (game_over)
  );

  task automatic check_eq(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_ALIVE;
    m_left  = 0;
    m_grace = 0;
    m_died  = 0;
    m_resp  = 0;
  endtask

  task automatic model_step(input bit hm, input bit hg, input bit nl, input bit sof);
    m_died = 0;
    m_resp = 0;
    case (m_mode)
      M_ALIVE: begin
        if ((hm || hg) && m_grace == 0) begin
          m_mode = M_DYING;
          m_left = DEATH;
        end else if (sof && m_grace > 0) begin
          m_grace--;
        end
      end
      M_DYING: begin
        if (m_left == 0) begin
          m_mode = M_DIED;
          m_died = 1;
        end else if (sof) begin
          m_left--;
        end
      end
      M_DIED: begin
        m_mode = M_WAIT;
        m_left = RESPAWN;
      end
      M_WAIT: begin
        if (m_left == 0) begin
          if (nl) begin
            m_mode = M_OVER;
          end else begin
            m_mode  = M_ALIVE;
            m_resp  = 1;
            m_grace = GRACE;
          end
        end else if (sof) begin
          m_left--;
        end
      end
      default: m_mode = M_OVER;
    endcase
  endtask

  function automatic int exp_visible();
    if (m_mode == M_ALIVE) begin
`ifdef PLAYER_DEATH_BLINK_EN
      if (m_grace == 0) return 1;
      return (((GRACE - m_grace) / BLINK) % 2 == 0) ? 1 : 0;
`else
      return 1;
`endif
    end
    return (m_mode == M_DYING) ? 1 : 0;
  endfunction

  task automatic compare_all(input string ctx);
    check_eq({ctx, ".player_died"}, player_died, m_died);
    check_eq({ctx, ".respawn"}, respawn, m_resp);
    check_eq({ctx, ".game_over"}, game_over, (m_mode == M_OVER) ? 1 : 0);
    // Only player_died is defined for the single DIED clk.
    if (m_mode != M_DIED) begin
      check_eq({ctx, ".player_freeze"}, player_freeze, (m_mode != M_ALIVE) ? 1 : 0);
      check_eq({ctx, ".dying_anim"}, dying_anim, (m_mode == M_DYING) ? 1 : 0);
      check_eq({ctx, ".player_visible"}, player_visible, exp_visible());
    end
    if (player_died === 1'b1) died_obs++;
    if (respawn === 1'b1) resp_obs++;
  endtask

  task automatic step(input string ctx, input bit hm, input bit hg, input bit nl, input bit sof);
    @(negedge clk);
    hit_monster  = hm;
    hit_gold     = hg;
    no_lives     = nl;
    startOfFrame = sof;
    model_step(hm, hg, nl, sof);
    @(posedge clk);
    #1;
    compare_all(ctx);
  endtask

  // Frame tick every third clk.
  task automatic run_idle(input string ctx, input int n, input bit nl);
    for (int i = 0; i < n; i++) step(ctx, 1'b0, 1'b0, nl, (i % 3) == 2);
  endtask

  task automatic async_reset(input string ctx);
    @(negedge clk);
    #2 resetN = 1'b0;
    #1;
    model_reset();
    compare_all(ctx);
    @(negedge clk);
    resetN = 1'b1;
    hit_monster  = 1'b0;
    hit_gold     = 1'b0;
    startOfFrame = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all("rst");
    @(negedge clk);
    resetN = 1'b1;

    // single hit -> one died pulse after 60 ticks, respawn 30 ticks later
    base_died = died_obs;
    base_resp = resp_obs;
    step("s1_hit", 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("s1_freeze_next_clk", player_freeze, 1);
    run_idle("s1", 300, 1'b0);
    check_eq("s1_died_count", died_obs - base_died, 1);
    check_eq("s1_respawn_count", resp_obs - base_resp, 1);

    // hits during grace are ignored
    base_died = died_obs;
    for (int i = 0; i < 5; i++) step("s4_grace_hit", 1'b1, 1'b1, 1'b0, (i % 2) == 1);
    run_idle("s4_grace", 280, 1'b0);
    check_eq("s4_grace_ignored", died_obs - base_died, 0);
    check_eq("s4_alive_after_grace", player_freeze, 0);

    // both collisions high for 5 clks -> a single death; no lives -> game over
    base_died = died_obs;
    for (int i = 0; i < 5; i++) step("s2_dual_hit", 1'b1, 1'b1, 1'b1, 1'b0);
    run_idle("s3", 300, 1'b1);
    check_eq("s2_died_count", died_obs - base_died, 1);
    check_eq("s3_game_over", game_over, 1);
    base_died = died_obs;
    for (int i = 0; i < 4; i++) step("s3_over_hit", 1'b1, 1'b0, 1'b0, 1'b1);
    run_idle("s3_over", 30, 1'b0);
    check_eq("s3_no_died_in_over", died_obs - base_died, 0);
    check_eq("s3_game_over_sticky", game_over, 1);

    // reset in the middle of DYING discards the sequence
    async_reset("s5_clear");
    base_died = died_obs;
    step("s5_hit", 1'b0, 1'b1, 1'b0, 1'b1);
    run_idle("s5_dying", 90, 1'b0);
    check_eq("s5_dying_before_reset", dying_anim, 1);
    async_reset("s5_reset");
    run_idle("s5_after", 20, 1'b0);
    check_eq("s5_no_died", died_obs - base_died, 0);

    // randomized play
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 2999) == 0 || (m_mode == M_OVER && over_cycles > 40)) begin
        async_reset("rnd_reset");
        over_cycles = 0;
      end else begin
        r_hm  = ($urandom_range(0, 49) == 0);
        r_hg  = ($urandom_range(0, 79) == 0);
        r_nl  = ($urandom_range(0, 2) == 0);
        r_sof = ($urandom_range(0, 3) == 0);
        step("rnd", r_hm, r_hg, r_nl, r_sof);
        if (m_mode == M_OVER) over_cycles++;
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
